// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised modulo up/down counter with clock enable,
// synchronous parallel load and a registered terminal-count pulse.
// Optional build macro: UPDOWN_SATURATE_EN -- when defined the counter pins at
// its bounds instead of wrapping; tc then stays high while pinned.
module param_updown_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = (1 << WIDTH) - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_C  = '0;
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("param_updown_counter: WIDTH must be 1..16");
        end
        if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
            $error("param_updown_counter: MAX_VAL must be 1..2**WIDTH-1");
        end
        if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
            $error("param_updown_counter: RESET_VAL must be 0..MAX_VAL");
        end
    endgenerate

    logic [WIDTH-1:0] next_count;
    logic             next_tc;

    // Next-state selection: load beats enable; bounds are tested before stepping.
    always_comb begin
        next_count = count;
        next_tc    = 1'b0;
        if (load) begin
            // Out-of-range load values clamp so count never exceeds MAX_VAL.
            next_count = (int'(load_val) > MAX_VAL) ? MAX_C : load_val;
        end else if (en) begin
            if (up_down) begin
                if (count == MAX_C) begin
`ifdef UPDOWN_SATURATE_EN
                    next_count = MAX_C;
`else
                    next_count = ZERO_C;
`endif
                    next_tc = 1'b1;
                end else begin
                    next_count = count + ONE_C;
                end
            end else begin
                if (count == ZERO_C) begin
`ifdef UPDOWN_SATURATE_EN
                    next_count = ZERO_C;
`else
                    next_count = MAX_C;
`endif
                    next_tc = 1'b1;
                end else begin
                    next_count = count - ONE_C;
                end
            end
        end
    end

    // State register; reset is asynchronous and drops any count in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_C;
            tc    <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= next_tc;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=3, MAX_VAL=5, RESET_VAL=0).
// A value-level model tracks the expected count/tc; a compare process checks
// the DUT against it on every falling edge, and directed steps carry literal
// expectations that pin the model itself.
module tb_param_updown_counter;

    localparam int WIDTH   = 3;
    localparam int MAX_VAL = 5;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;

    int vectors;
    int miscompares;

    int m_count;
    int m_tc;

    param_updown_counter #(
        .WIDTH(WIDTH),
        .MAX_VAL(MAX_VAL),
        .RESET_VAL(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .up_down(up_down),
        .load(load),
        .load_val(load_val),
        .count(count),
        .tc(tc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counting rules applied to plain integers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0;
            m_tc    = 0;
        end else if (load) begin
            m_count = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
            m_tc    = 0;
        end else if (en) begin
            if (up_down) begin
                m_tc = (m_count == MAX_VAL) ? 1 : 0;
`ifdef UPDOWN_SATURATE_EN
                m_count = (m_count == MAX_VAL) ? MAX_VAL : m_count + 1;
`else
                m_count = (m_count + 1) % (MAX_VAL + 1);
`endif
            end else begin
                m_tc = (m_count == 0) ? 1 : 0;
`ifdef UPDOWN_SATURATE_EN
                m_count = (m_count == 0) ? 0 : m_count - 1;
`else
                m_count = (m_count + MAX_VAL) % (MAX_VAL + 1);
`endif
            end
        end else begin
            m_tc = 0;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        check("model_count", int'(count), m_count);
        check("model_tc", int'(tc), m_tc);
    end

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_expect(input string name, input int exp_count, input int exp_tc);
        tick();
        check({name, "_count"}, int'(count), exp_count);
        check({name, "_tc"}, int'(tc), exp_tc);
    endtask

    task automatic set_inputs(input logic e, input logic ud, input logic ld, input int lv);
        en       = e;
        up_down  = ud;
        load     = ld;
        load_val = WIDTH'(lv);
    endtask

    initial begin
        int up_seq[8];
        up_seq = '{1, 2, 3, 4, 5, 0, 1, 2};
        vectors     = 0;
        miscompares = 0;

        // Reset
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 0);
        #2;
        check("reset_count", int'(count), 0);
        check("reset_tc", int'(tc), 0);
        tick();
        rst_n = 1'b1;

`ifndef UPDOWN_SATURATE_EN
        // Count up across the wrap: tc only where count shows 0.
        set_inputs(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            step_expect("up_wrap", up_seq[i], (up_seq[i] == 0) ? 1 : 0);
        end
        for (int i = 3; i < 6; i++) step_expect("up_more", i, 0);
        step_expect("up_to_zero", 0, 1);

        // Down from 0 wraps to MAX_VAL on the same edge the direction changes.
        set_inputs(1'b1, 1'b0, 1'b0, 0);
        step_expect("down_wrap", 5, 1);
        step_expect("down_step", 4, 0);
`endif

        // Load beats enable; out-of-range values clamp.
        set_inputs(1'b1, 1'b1, 1'b1, 3);
        step_expect("load_3", 3, 0);
        set_inputs(1'b1, 1'b0, 1'b1, 7);
        step_expect("load_clamp", 5, 0);
        set_inputs(1'b0, 1'b0, 1'b1, 2);
        step_expect("load_2", 2, 0);

        // Hold with direction toggling.
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b0, 1'(i % 2), 1'b0, 0);
            step_expect("hold", 2, 0);
        end

        // Asynchronous reset between edges at count=4.
        set_inputs(1'b1, 1'b1, 1'b0, 0);
        step_expect("pre_rst_a", 3, 0);
        step_expect("pre_rst_b", 4, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_tc", int'(tc), 0);
        tick();
        rst_n = 1'b1;
        step_expect("resume", 1, 0);

`ifdef UPDOWN_SATURATE_EN
        // Saturation at both bounds.
        set_inputs(1'b0, 1'b1, 1'b1, 4);
        step_expect("sat_load", 4, 0);
        set_inputs(1'b1, 1'b1, 1'b0, 0);
        step_expect("sat_up_a", 5, 0);
        step_expect("sat_up_b", 5, 1);
        step_expect("sat_up_c", 5, 1);
        set_inputs(1'b0, 1'b0, 1'b1, 0);
        step_expect("sat_load0", 0, 0);
        set_inputs(1'b1, 1'b0, 1'b0, 0);
        step_expect("sat_down", 0, 1);
`endif

        // Mixed directed pattern, checked by the model only.
        for (int i = 0; i < 40; i++) begin
            set_inputs(1'((i % 3) != 0), 1'((i / 5) % 2), 1'(i == 17 || i == 29),
                       (i == 17) ? 6 : 1);
            tick();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
